// File: rtl/one_port_mem_if.sv
// Single-port memory bus: shared address, write port and registered read data.
// Requester side is master, the memory itself is slave.
interface one_port_mem_if #(
   parameter int addressWidth = 5,
   parameter int width        = 8
);
   logic [addressWidth-1:0] address;
   logic                    readEnable;
   logic                    writeEnable;
   logic [width-1:0]        writeData;
   logic [width-1:0]        readData;

   modport master (
      output address, readEnable, writeEnable, writeData,
      input  readData
   );

   modport slave (
      input  address, readEnable, writeEnable, writeData,
      output readData
   );
endinterface

// File: rtl/one_port_mem.sv
// Generic single-port synchronous RAM with column-mux organisation and registered read.
// Optional write-through on simultaneous read/write: define ONE_PORT_MEM_WRITE_THROUGH_EN.
module one_port_mem #(
   parameter int addresses = 32,
   parameter int width     = 8,
   parameter int muxFactor = 0
) (
   input logic           clk,
   input logic           reset,
   one_port_mem_if.slave bus
);
   localparam int addressWidth = (addresses > 1) ? $clog2(addresses) : 1;
   localparam int cols         = 1 << muxFactor;
   localparam int rows         = (addresses + cols - 1) / cols;
   localparam int rowBits      = (rows > 1) ? $clog2(rows) : 1;
   localparam int colBits      = (muxFactor > 0) ? muxFactor : 1;

   // Each physical row holds 2^muxFactor logical words side by side.
   logic [cols-1:0][width-1:0] mem [rows];

   logic [addressWidth-1:0]    address;
   logic [rowBits-1:0]         row;
   logic [colBits-1:0]         col;
   logic                       inRange;
   logic [cols-1:0][width-1:0] rowRd;
   logic [cols-1:0][width-1:0] rowWr;
   logic [width-1:0]           rdWord;
   logic [width-1:0]           readData;

   assign address = bus.address;
   assign inRange = ({1'b0, address} < (addressWidth + 1)'(addresses));
   assign row     = rowBits'(address >> muxFactor);
   assign col     = (muxFactor > 0) ? colBits'(address) : '0;

   assign rowRd   = mem[row];
   assign rdWord  = rowRd[col];

   // Read-modify-write: only the addressed column slice changes.
   always_comb begin
      rowWr      = rowRd;
      rowWr[col] = bus.writeData;
   end

   always_ff @(posedge clk) begin
      if (!reset && bus.writeEnable && inRange)
         mem[row] <= rowWr;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         readData <= '0;
      end else if (bus.readEnable) begin
`ifdef ONE_PORT_MEM_WRITE_THROUGH_EN
         if (bus.writeEnable)
            readData <= bus.writeData;
         else
            readData <= inRange ? rdWord : '0;
`else
         // A read colliding with a write is dropped; readData holds.
         if (!bus.writeEnable)
            readData <= inRange ? rdWord : '0;
`endif
      end
   end

   assign bus.readData = readData;
endmodule

// File: tb/tb_one_port_mem.sv
// Self-checking bench: a 32x8 flat instance and a 30x8 muxFactor=2 instance
// checked against array models of the logical memory.
module tb_one_port_mem;
   logic clk = 1'b0;
   logic reset;
   int   cmp  = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   one_port_mem_if #(.addressWidth(5), .width(8)) busA ();
   one_port_mem_if #(.addressWidth(5), .width(8)) busB ();

   one_port_mem #(.addresses(32), .width(8), .muxFactor(0)) dutA (
      .clk(clk), .reset(reset), .bus(busA)
   );
   one_port_mem #(.addresses(30), .width(8), .muxFactor(2)) dutB (
      .clk(clk), .reset(reset), .bus(busB)
   );

   logic [7:0] memA [32];
   logic [7:0] memB [32];
   logic [7:0] expA;
   logic [7:0] expB;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      cmp++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idleB();
      busB.readEnable = 1'b0; busB.writeEnable = 1'b0;
      busB.address = '0;      busB.writeData = '0;
   endtask

   task automatic idleA();
      busA.readEnable = 1'b0; busA.writeEnable = 1'b0;
      busA.address = '0;      busA.writeData = '0;
   endtask

   // One cycle on instance A, then compare against the model.
   task automatic opA(input logic re, input logic we, input logic [4:0] a,
                      input logic [7:0] d, input string tag);
      busA.readEnable = re; busA.writeEnable = we;
      busA.address = a;     busA.writeData = d;
      idleB();
      @(posedge clk); #1;
      if (re && !we) expA = memA[a];
`ifdef ONE_PORT_MEM_WRITE_THROUGH_EN
      if (re && we) expA = d;
`endif
      if (we) memA[a] = d;
      chk(tag, busA.readData, expA);
   endtask

   // One cycle on instance B; words 30 and 31 do not exist.
   task automatic opB(input logic re, input logic we, input logic [4:0] a,
                      input logic [7:0] d, input string tag);
      busB.readEnable = re; busB.writeEnable = we;
      busB.address = a;     busB.writeData = d;
      idleA();
      @(posedge clk); #1;
      if (re && !we) expB = (a < 30) ? memB[a] : 8'h00;
`ifdef ONE_PORT_MEM_WRITE_THROUGH_EN
      if (re && we) expB = d;
`endif
      if (we && a < 30) memB[a] = d;
      chk(tag, busB.readData, expB);
   endtask

   // Reset cycle: A may carry a write/read request that must be suppressed.
   task automatic rst(input logic we, input logic [4:0] a, input logic [7:0] d);
      reset = 1'b1;
      busA.readEnable = we; busA.writeEnable = we;
      busA.address = a;     busA.writeData = d;
      idleB();
      @(posedge clk); #1;
      reset = 1'b0;
      expA = 8'h00; expB = 8'h00;
      chk("resetA", busA.readData, expA);
      chk("resetB", busB.readData, expB);
   endtask

   initial begin
      logic       re, we, sel;
      logic [4:0] a;
      logic [7:0] d;
      reset = 1'b1;
      idleA(); idleB();
      rst(1'b0, 5'd0, 8'h00);
      rst(1'b0, 5'd0, 8'h00);

      // Fill and read back the flat instance.
      for (int i = 0; i < 32; i++) opA(1'b0, 1'b1, 5'(i), 8'(i), "fillA");
      for (int i = 0; i < 10; i++) opA(1'b0, 1'b0, 5'd0, 8'h00, "idleA");
      for (int i = 0; i < 32; i++) opA(1'b1, 1'b0, 5'(i), 8'h00, "readbackA");

      // Hold with readEnable low while the address moves.
      opA(1'b1, 1'b0, 5'd5, 8'h00, "hold_rd5");
      for (int i = 0; i < 3; i++) opA(1'b0, 1'b0, 5'd9, 8'h00, "hold");

      // Reset beats a pending write.
      opA(1'b1, 1'b0, 5'd7, 8'h00, "pre_reset_rd7");
      rst(1'b1, 5'd3, 8'hAA);
      opA(1'b1, 1'b0, 5'd3, 8'h00, "post_reset_rd3");

      // Simultaneous read and write.
      opA(1'b1, 1'b1, 5'd4, 8'h55, "rw_same_cycle");
      opA(1'b1, 1'b0, 5'd4, 8'h00, "rw_readback");

      // Column mux: neighbouring columns must survive a rewrite.
      for (int i = 0; i < 4; i++) opB(1'b0, 1'b1, 5'(8 + i), 8'(8'hA0 + i), "muxWr");
      opB(1'b0, 1'b1, 5'd9, 8'h11, "muxRewrite");
      for (int i = 0; i < 4; i++) opB(1'b1, 1'b0, 5'(8 + i), 8'h00, "muxRd");
      opB(1'b0, 1'b1, 5'd31, 8'hEE, "oorWr");
      opB(1'b1, 1'b0, 5'd31, 8'h00, "oorRd");
      for (int i = 0; i < 4; i++) opB(1'b1, 1'b0, 5'(8 + i), 8'h00, "muxRd2");
      for (int i = 0; i < 30; i++) opB(1'b0, 1'b1, 5'(i), 8'($urandom), "fillB");

      // Back-to-back write/read of each word.
      for (int k = 0; k < 32; k++) begin
         opA(1'b0, 1'b1, 5'(k), 8'($urandom), "b2bWr");
         opA(1'b1, 1'b0, 5'(k), 8'h00, "b2bRd");
      end

      // Randomized mix on both instances, with occasional resets.
      for (int n = 0; n < 400; n++) begin
         re  = 1'($urandom); we = 1'($urandom); sel = 1'($urandom);
         a   = 5'($urandom_range(31)); d = 8'($urandom);
         if ($urandom_range(39) == 0) rst(we, a, d);
         else if (sel) opB(re, we, a, d, "randB");
         else          opA(re, we, a, d, "randA");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end
endmodule
